reg_writeback: RTL and testbench

- Write-side companion of the physical register file read stage.
- Collects completed results from NUM_SRC functional units (ALU, MEM, MUL/DIV) into per-source FIFOs.
- Round-robin arbitrates them onto the single physical-register write port (WriteReg1/WriteData1/Write1) and maintains the architectural hi/lo pair.
- Broadcasts a wakeup tag for each register written, so the issue queue can mark operands ready.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 50 +++++
 rtl/reg_writeback.sv | 124 ++++++++++++
 tb/tb_reg_writeback.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback slice: entry layout, tag width
// derivation and the reserved zero-register tag.
package wb_pkg;

   function automatic int unsigned logPhys(input int unsigned numRegs);
      return (numRegs > 1) ? $clog2(numRegs) : 1;
   endfunction

   localparam int unsigned WB_NUM_PHYS = 64;
   localparam int unsigned WB_LOG_PHYS = logPhys(WB_NUM_PHYS);

   localparam logic [WB_LOG_PHYS-1:0] WB_ZERO_TAG = '0;

   typedef struct packed {
      logic [WB_LOG_PHYS-1:0] tag;
      logic [31:0]            data;
      logic [31:0]            hidata;
      logic                   hilo;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO with synchronous flush; pointers carry one extra
// wrap bit so full and empty are told apart without a counter.
module wb_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic [WIDTH-1:0] mem [DEPTH];

   always_comb begin
      empty   = (wrPtr == rdPtr);
      full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
      popData = mem[rdPtr[AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push && !full)
            wrPtr <= wrPtr + 1'b1;
         if (pop && !empty)
            rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full && !flush)
         mem[wrPtr[AW-1:0]] <= pushData;
   end

endmodule

// File: rtl/reg_writeback.sv
// Collects functional-unit results into per-source FIFOs, round-robin drains
// them onto the register-file write port, maintains hi/lo and broadcasts wakeups.
module reg_writeback
   import wb_pkg::*;
#(
   parameter int unsigned NUM_PHYS_REGS = WB_NUM_PHYS,
   parameter int unsigned NUM_SRC       = 3,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned LOG_PHYS      = logPhys(NUM_PHYS_REGS)
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         Flush,
   input  logic [NUM_SRC-1:0]           SrcValid,
   output logic [NUM_SRC-1:0]           SrcReady,
   input  logic [NUM_SRC*LOG_PHYS-1:0]  SrcPhysReg,
   input  logic [NUM_SRC*32-1:0]        SrcData,
   input  logic [NUM_SRC*32-1:0]        SrcHiData,
   input  logic [NUM_SRC-1:0]           SrcHiLo,
   output logic [LOG_PHYS-1:0]          WriteReg1,
   output logic [31:0]                  WriteData1,
   output logic                         Write1,
   output logic [31:0]                  hi,
   output logic [31:0]                  lo,
   output logic                         WakeValid,
   output logic [LOG_PHYS-1:0]          WakeTag
);

   localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   wb_entry_t            pushEntry [NUM_SRC];
   wb_entry_t            popEntry  [NUM_SRC];
   logic [NUM_SRC-1:0]   full;
   logic [NUM_SRC-1:0]   empty;
   logic [NUM_SRC-1:0]   push;
   logic [NUM_SRC-1:0]   pop;

   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     ptrNext;
   logic                 grantValid;
   wb_entry_t            grantEntry;

   // Tags are stored at the package tag width; the casts keep the port width
   // independent of the stored entry layout.
   always_comb begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         pushEntry[i].tag    = WB_LOG_PHYS'(SrcPhysReg[i*LOG_PHYS +: LOG_PHYS]);
         pushEntry[i].data   = SrcData[i*32 +: 32];
         pushEntry[i].hidata = SrcHiData[i*32 +: 32];
         pushEntry[i].hilo   = SrcHiLo[i];
      end
      SrcReady = ~full;
      push     = SrcValid & ~full;
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : genFifo
      wb_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH ($bits(wb_entry_t))
      ) uFifo (
         .clk      (CLK),
         .rst      (RESET),
         .flush    (Flush),
         .push     (push[g]),
         .pushData (pushEntry[g]),
         .pop      (pop[g]),
         .popData  (popEntry[g]),
         .full     (full[g]),
         .empty    (empty[g])
      );
   end

   always_comb begin
      int unsigned idx;
      grantValid = 1'b0;
      grantEntry = '0;
      pop        = '0;
      ptrNext    = ptr;
      idx        = 0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         idx = (32'(ptr) + k) % NUM_SRC;
         if (!grantValid && !empty[idx]) begin
            grantValid = 1'b1;
            grantEntry = popEntry[idx];
            pop[idx]   = 1'b1;
            ptrNext    = PTR_W'((idx + 1) % NUM_SRC);
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ptr        <= '0;
         Write1     <= 1'b0;
         WakeValid  <= 1'b0;
         WriteReg1  <= '0;
         WriteData1 <= '0;
         WakeTag    <= '0;
         hi         <= '0;
         lo         <= '0;
      end else if (Flush) begin
         ptr       <= '0;
         Write1    <= 1'b0;
         WakeValid <= 1'b0;
      end else begin
         ptr       <= ptrNext;
         Write1    <= 1'b0;
         WakeValid <= 1'b0;
         if (grantValid) begin
            if (grantEntry.hilo) begin
               hi <= grantEntry.hidata;
               lo <= grantEntry.data;
            end else if (grantEntry.tag != WB_ZERO_TAG) begin
               Write1     <= 1'b1;
               WriteReg1  <= LOG_PHYS'(grantEntry.tag);
               WriteData1 <= grantEntry.data;
               WakeValid  <= 1'b1;
               WakeTag    <= LOG_PHYS'(grantEntry.tag);
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: latency, round-robin order, backpressure,
// hi/lo updates, zero-tag drop, flush and asynchronous reset.
module tb_reg_writeback;

   localparam int NS = 3;
   localparam int LP = 6;

   logic             CLK = 1'b0;
   logic             RESET;
   logic             Flush;
   logic [NS-1:0]    SrcValid;
   logic [NS-1:0]    SrcReady;
   logic [NS*LP-1:0] SrcPhysReg;
   logic [NS*32-1:0] SrcData;
   logic [NS*32-1:0] SrcHiData;
   logic [NS-1:0]    SrcHiLo;
   logic [LP-1:0]    WriteReg1;
   logic [31:0]      WriteData1;
   logic             Write1;
   logic [31:0]      hi;
   logic [31:0]      lo;
   logic             WakeValid;
   logic [LP-1:0]    WakeTag;

   int checks = 0;
   int errors = 0;
   int n0, n1, n2, c0, c1, c2;
   logic [NS-1:0] rdy, vld;
   logic [LP-1:0] t;
   logic [LP-1:0] wqTag [$];
   logic [31:0]   wqData [$];

   always #5 CLK = ~CLK;

   reg_writeback #(
      .NUM_PHYS_REGS (64),
      .NUM_SRC       (NS),
      .FIFO_DEPTH    (4)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .Flush      (Flush),
      .SrcValid   (SrcValid),
      .SrcReady   (SrcReady),
      .SrcPhysReg (SrcPhysReg),
      .SrcData    (SrcData),
      .SrcHiData  (SrcHiData),
      .SrcHiLo    (SrcHiLo),
      .WriteReg1  (WriteReg1),
      .WriteData1 (WriteData1),
      .Write1     (Write1),
      .hi         (hi),
      .lo         (lo),
      .WakeValid  (WakeValid),
      .WakeTag    (WakeTag)
   );

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
      end
   endtask

   function automatic logic [31:0] dataOf(input logic [LP-1:0] tg);
      return 32'hC0DE_0000 | {26'h0, tg};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
      if (Write1 === 1'b1) begin
         wqTag.push_back(WriteReg1);
         wqData.push_back(WriteData1);
         check("wake with write", 32'(WakeValid), 1);
      end
   endtask

   task automatic setSrc(input int i, input logic v, input logic [LP-1:0] tg,
                         input logic [31:0] d, input logic [31:0] hd, input logic hl);
      SrcValid[i]            = v;
      SrcPhysReg[i*LP +: LP] = tg;
      SrcData[i*32 +: 32]    = d;
      SrcHiData[i*32 +: 32]  = hd;
      SrcHiLo[i]             = hl;
   endtask

   task automatic idle();
      SrcValid = '0;
      SrcHiLo  = '0;
   endtask

   task automatic clearQ();
      wqTag.delete();
      wqData.delete();
   endtask

   initial begin
      RESET = 1'b1; Flush = 1'b0;
      SrcValid = '0; SrcHiLo = '0; SrcPhysReg = '0; SrcData = '0; SrcHiData = '0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset Write1", 32'(Write1), 0);
      check("reset WakeValid", 32'(WakeValid), 0);
      check("reset WriteReg1", 32'(WriteReg1), 0);
      check("reset WriteData1", WriteData1, 0);
      check("reset WakeTag", 32'(WakeTag), 0);
      check("reset hi", hi, 0);
      check("reset lo", lo, 0);
      RESET = 1'b0;
      #1;
      check("ready after reset", 32'(SrcReady), 32'h7);

      // single push from src1, two-cycle latency
      setSrc(1, 1'b1, 6'd5, 32'hDEADBEEF, 32'h0, 1'b0);
      tick(); idle();
      check("t1 cycle1 no write", 32'(Write1), 0);
      tick();
      check("t1 Write1", 32'(Write1), 1);
      check("t1 WriteReg1", 32'(WriteReg1), 5);
      check("t1 WriteData1", WriteData1, 32'hDEADBEEF);
      check("t1 WakeValid", 32'(WakeValid), 1);
      check("t1 WakeTag", 32'(WakeTag), 5);
      tick();
      check("t1 cycle3 Write1", 32'(Write1), 0);
      check("t1 cycle3 WakeValid", 32'(WakeValid), 0);
      clearQ();

      // flush returns ptr to 0, then three simultaneous pushes
      Flush = 1'b1; tick(); Flush = 1'b0;
      for (int i = 0; i < NS; i++) setSrc(i, 1'b1, LP'(i + 1), dataOf(LP'(i + 1)), 32'h0, 1'b0);
      tick(); idle();
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("t2 Write1", 32'(Write1), 1);
         check("t2 WriteReg1 order", 32'(WriteReg1), k);
         check("t2 WriteData1", WriteData1, dataOf(LP'(k)));
      end
      tick();
      check("t2 idle Write1", 32'(Write1), 0);
      clearQ();

      // src0 streams while src1/src2 stay busy
      n0 = 0; n1 = 0; n2 = 0;
      for (int cyc = 1; cyc <= 40 && n0 < 8; cyc++) begin
         setSrc(0, 1'b1, LP'(16 + n0), dataOf(LP'(16 + n0)), 32'h0, 1'b0);
         setSrc(1, cyc <= 12, LP'(32 + n1), dataOf(LP'(32 + n1)), 32'h0, 1'b0);
         setSrc(2, cyc <= 12, LP'(48 + n2), dataOf(LP'(48 + n2)), 32'h0, 1'b0);
         rdy = SrcReady;
         vld = SrcValid;
         tick();
         if (vld[0] && rdy[0]) n0++;
         if (vld[1] && rdy[1]) n1++;
         if (vld[2] && rdy[2]) n2++;
         if (cyc == 5) check("t3 src0 ready after 5 pushes", 32'(SrcReady[0]), 1);
         if (cyc == 6) check("t3 src0 full after 6 pushes", 32'(SrcReady[0]), 0);
      end
      idle();
      check("t3 src0 accepted", n0, 8);
      repeat (40) tick();
      c0 = 0; c1 = 0; c2 = 0;
      foreach (wqTag[k]) begin
         t = wqTag[k];
         check("t3 data", wqData[k], dataOf(t));
         if (t >= 6'h10 && t < 6'h20) begin
            check("t3 src0 order", 32'(t), 16 + c0); c0++;
         end else if (t >= 6'h20 && t < 6'h30) begin
            check("t3 src1 order", 32'(t), 32 + c1); c1++;
         end else begin
            check("t3 src2 order", 32'(t), 48 + c2); c2++;
         end
      end
      check("t3 src0 count", c0, 8);
      check("t3 src1 count", c1, n1);
      check("t3 src2 count", c2, n2);
      clearQ();

      // hi/lo entry from src2
      setSrc(2, 1'b1, 6'd7, 32'h2, 32'h1, 1'b1);
      tick(); idle();
      check("t4 cycle1 hi", hi, 0);
      check("t4 cycle1 Write1", 32'(Write1), 0);
      tick();
      check("t4 hi", hi, 1);
      check("t4 lo", lo, 2);
      check("t4 Write1", 32'(Write1), 0);
      check("t4 WakeValid", 32'(WakeValid), 0);
      tick();
      check("t4 no writes", wqTag.size(), 0);

      // zero tag dropped, next entry written normally
      setSrc(0, 1'b1, 6'd0, dataOf(6'd0), 32'h0, 1'b0);
      setSrc(1, 1'b1, 6'd9, dataOf(6'd9), 32'h0, 1'b0);
      tick(); idle();
      tick();
      check("t5 zero tag Write1", 32'(Write1), 0);
      check("t5 zero tag WakeValid", 32'(WakeValid), 0);
      tick();
      check("t5 next Write1", 32'(Write1), 1);
      check("t5 next WriteReg1", 32'(WriteReg1), 9);
      check("t5 next WriteData1", WriteData1, dataOf(6'd9));
      tick();
      check("t5 write count", wqTag.size(), 1);
      clearQ();

      // flush with queued entries and a concurrent push
      for (int i = 0; i < NS; i++) setSrc(i, 1'b1, LP'(11 + i), dataOf(LP'(11 + i)), 32'h0, 1'b0);
      tick(); idle();
      setSrc(0, 1'b1, 6'd14, dataOf(6'd14), 32'h0, 1'b0);
      Flush = 1'b1;
      tick();
      Flush = 1'b0; idle();
      check("t6 ready after flush", 32'(SrcReady), 32'h7);
      check("t6 Write1", 32'(Write1), 0);
      check("t6 WakeValid", 32'(WakeValid), 0);
      repeat (6) tick();
      check("t6 no writes", wqTag.size(), 0);
      check("t6 hi kept", hi, 1);
      check("t6 lo kept", lo, 2);

      // asynchronous reset mid-stream
      setSrc(0, 1'b1, 6'd20, dataOf(6'd20), 32'h0, 1'b0);
      setSrc(1, 1'b1, 6'd21, dataOf(6'd21), 32'h0, 1'b0);
      tick(); idle();
      tick();
      check("t7 write before reset", 32'(Write1), 1);
      #2 RESET = 1'b1;
      #1;
      check("t7 async Write1", 32'(Write1), 0);
      check("t7 async WriteReg1", 32'(WriteReg1), 0);
      check("t7 async WriteData1", WriteData1, 0);
      check("t7 async WakeValid", 32'(WakeValid), 0);
      check("t7 async WakeTag", 32'(WakeTag), 0);
      check("t7 async hi", hi, 0);
      check("t7 async lo", lo, 0);
      @(posedge CLK);
      #1 RESET = 1'b0;
      clearQ();
      #1;
      check("t7 ready after reset", 32'(SrcReady), 32'h7);
      repeat (4) tick();
      check("t7 in-flight lost", wqTag.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
